// File: rtl/ctrl_pkg.sv
// Shared definitions for the WISC pipelined control unit:
// opcodes, control-bundle layout and bubble constants.
package ctrl_pkg;

    localparam int CW = 18;

    // Bundle field bit positions, MSB to LSB
    localparam int B_ALU_HI   = 17;
    localparam int B_ALU_LO   = 13;
    localparam int B_VALID    = 12;
    localparam int B_HALT     = 11;
    localparam int B_ERR      = 10;
    localparam int B_ZERO_EXT = 9;
    localparam int B_FIVE_IMM = 8;
    localparam int B_REG_WR   = 7;
    localparam int B_ALU_SRC  = 6;
    localparam int B_MEM_WR   = 5;
    localparam int B_MEM2REG  = 4;
    localparam int B_MEM_RD   = 3;
    localparam int B_BRANCH   = 2;
    localparam int B_JUMP     = 1;
    localparam int B_REG_DST  = 0;

    typedef logic [CW-1:0] ctrl_t;

    localparam ctrl_t BUBBLE = '0;
    localparam ctrl_t ERR_BUBBLE =
        ctrl_t'((1 << B_VALID) | (1 << B_ERR));

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_ADD   = 5'b11011;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: opcode plus fetch fault
// to a control bundle (valid always set here).
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0]    op,
    input  logic          fault,
    output logic [CW-1:0] ctrl
);

    // Decode opcode classes into control flags
    always_comb begin
        ctrl = BUBBLE;
        ctrl[B_ALU_HI:B_ALU_LO] = op;
        ctrl[B_VALID] = 1'b1;
        unique case (1'b1)
            (op == OP_HALT): begin
                ctrl[B_HALT] = 1'b1;
            end
            (op inside {OP_NOP, OP_SIIC, OP_RTI}): begin
            end
            (op[4:2] == 3'b010): begin
                ctrl[B_FIVE_IMM] = 1'b1;
                ctrl[B_ALU_SRC]  = 1'b1;
                ctrl[B_REG_WR]   = 1'b1;
                ctrl[B_ZERO_EXT] = op[1];
            end
            (op[4:2] == 3'b101): begin
                ctrl[B_FIVE_IMM] = 1'b1;
                ctrl[B_ALU_SRC]  = 1'b1;
                ctrl[B_REG_WR]   = 1'b1;
            end
            (op == OP_ST): begin
                ctrl[B_FIVE_IMM] = 1'b1;
                ctrl[B_ALU_SRC]  = 1'b1;
                ctrl[B_MEM_WR]   = 1'b1;
            end
            (op == OP_LD): begin
                ctrl[B_FIVE_IMM] = 1'b1;
                ctrl[B_ALU_SRC]  = 1'b1;
                ctrl[B_MEM_RD]   = 1'b1;
                ctrl[B_MEM2REG]  = 1'b1;
                ctrl[B_REG_WR]   = 1'b1;
            end
            (op == OP_STU): begin
                ctrl[B_FIVE_IMM] = 1'b1;
                ctrl[B_ALU_SRC]  = 1'b1;
                ctrl[B_MEM_WR]   = 1'b1;
                ctrl[B_REG_WR]   = 1'b1;
            end
            (op == OP_SLBI): begin
                ctrl[B_ALU_SRC]  = 1'b1;
                ctrl[B_REG_WR]   = 1'b1;
                ctrl[B_ZERO_EXT] = 1'b1;
            end
            (op == OP_BTR || op[4:1] == 4'b1101
                || op[4:2] == 3'b111): begin
                ctrl[B_REG_DST] = 1'b1;
                ctrl[B_REG_WR]  = 1'b1;
            end
            (op[4:2] == 3'b011): begin
                ctrl[B_ALU_SRC] = 1'b1;
                ctrl[B_BRANCH]  = 1'b1;
            end
            (op == OP_LBI): begin
                ctrl[B_ALU_SRC] = 1'b1;
                ctrl[B_REG_WR]  = 1'b1;
            end
            (op == OP_J): begin
                ctrl[B_JUMP] = 1'b1;
            end
            (op == OP_JR): begin
                ctrl[B_JUMP]    = 1'b1;
                ctrl[B_ALU_SRC] = 1'b1;
            end
            (op == OP_JAL): begin
                ctrl[B_JUMP]   = 1'b1;
                ctrl[B_REG_WR] = 1'b1;
            end
            (op == OP_JALR): begin
                ctrl[B_JUMP]    = 1'b1;
                ctrl[B_REG_WR]  = 1'b1;
                ctrl[B_ALU_SRC] = 1'b1;
            end
            default: begin
            end
        endcase
        if (fault) begin
            ctrl = ERR_BUBBLE;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decode, EX/MEM/WB bundle registers,
// stall/flush/halt sequencing. Optional hazard: CTRL_LOADUSE_EN.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [4:0]        if_op,
    input  logic [REG_AW-1:0] if_rs,
    input  logic [REG_AW-1:0] if_rt,
    input  logic [REG_AW-1:0] if_rd,
    input  logic              if_fault,
    input  logic              stall_ext,
    input  logic              flush,
    output logic              id_stall,
    output logic [CW-1:0]     ex_ctrl,
    output logic [CW-1:0]     mem_ctrl,
    output logic [CW-1:0]     wb_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd,
    output logic              halt_out,
    output logic              err_out
);

    ctrl_t             dec_ctrl;
    ctrl_t             id_ctrl;
    logic [REG_AW-1:0] id_rd;
    logic              id_live;
    logic              load_use;
    logic              id_bubble;
    logic              halt_pending;
    logic              halt_q;
    logic              err_q;
    logic              wb_halt;
    logic              wb_err;

    ctrl_decode u_dec (
        .op    (if_op),
        .fault (if_fault),
        .ctrl  (dec_ctrl)
    );

    assign id_live = if_valid && !halt_pending;
    assign id_ctrl = id_live ? dec_ctrl : BUBBLE;
    assign id_rd   = (id_live && !if_fault) ? if_rd : '0;

`ifdef CTRL_LOADUSE_EN
    assign load_use = ex_ctrl[B_VALID] && ex_ctrl[B_MEM_RD]
                   && ex_ctrl[B_REG_WR] && if_valid
                   && (ex_rd == if_rs || ex_rd == if_rt);
`else
    logic unused_src;
    assign unused_src = ^{if_rs, if_rt};
    assign load_use   = 1'b0;
`endif

    assign id_stall  = load_use && !flush;
    assign id_bubble = flush || load_use;

    // Stage registers: stall holds all, otherwise advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl      <= BUBBLE;
            mem_ctrl     <= BUBBLE;
            wb_ctrl      <= BUBBLE;
            ex_rd        <= '0;
            mem_rd       <= '0;
            wb_rd        <= '0;
            halt_pending <= 1'b0;
        end else if (!stall_ext) begin
            mem_ctrl <= ex_ctrl;
            mem_rd   <= ex_rd;
            wb_ctrl  <= mem_ctrl;
            wb_rd    <= mem_rd;
            if (id_bubble) begin
                ex_ctrl <= BUBBLE;
                ex_rd   <= '0;
            end else begin
                ex_ctrl <= id_ctrl;
                ex_rd   <= id_rd;
                if (id_ctrl[B_VALID] && id_ctrl[B_HALT]) begin
                    halt_pending <= 1'b1;
                end
            end
        end
    end

    assign wb_halt = wb_ctrl[B_VALID] && wb_ctrl[B_HALT];
    assign wb_err  = wb_ctrl[B_VALID] && wb_ctrl[B_ERR];

    // Sticky halt/error flags, set by the retiring bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            halt_q <= halt_q || wb_halt;
            err_q  <= err_q || wb_err;
        end
    end

    assign halt_out = halt_q || wb_halt;
    assign err_out  = err_q || wb_err;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed vectors,
// WB monitor pops expected bundles from a queue.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    localparam int AW = 3;

    localparam logic [17:0] K_ADDI = 18'b01000_1_0_0_0_1_1_1_0_0_0_0_0_0;
    localparam logic [17:0] K_XORI = 18'b01010_1_0_0_1_1_1_1_0_0_0_0_0_0;
    localparam logic [17:0] K_ST   = 18'b10000_1_0_0_0_1_0_1_1_0_0_0_0_0;
    localparam logic [17:0] K_LD   = 18'b10001_1_0_0_0_1_1_1_0_1_1_0_0_0;
    localparam logic [17:0] K_STU  = 18'b10011_1_0_0_0_1_1_1_1_0_0_0_0_0;
    localparam logic [17:0] K_SLBI = 18'b10010_1_0_0_1_0_1_1_0_0_0_0_0_0;
    localparam logic [17:0] K_BEQZ = 18'b01100_1_0_0_0_0_0_1_0_0_0_1_0_0;
    localparam logic [17:0] K_JR   = 18'b00101_1_0_0_0_0_0_1_0_0_0_0_1_0;
    localparam logic [17:0] K_JAL  = 18'b00110_1_0_0_0_0_1_0_0_0_0_0_1_0;
    localparam logic [17:0] K_ADD  = 18'b11011_1_0_0_0_0_1_0_0_0_0_0_0_1;
    localparam logic [17:0] K_BTR  = 18'b11001_1_0_0_0_0_1_0_0_0_0_0_0_1;
    localparam logic [17:0] K_LBI  = 18'b11000_1_0_0_0_0_1_1_0_0_0_0_0_0;
    localparam logic [17:0] K_ROLI = 18'b10100_1_0_0_0_1_1_1_0_0_0_0_0_0;
    localparam logic [17:0] K_HALT = 18'b00000_1_1_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [17:0] K_FLT  = 18'b00000_1_0_1_0_0_0_0_0_0_0_0_0_0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          if_valid, if_fault, stall_ext, flush;
    logic [4:0]    if_op;
    logic [AW-1:0] if_rs, if_rt, if_rd;
    logic          id_stall, halt_out, err_out;
    logic [CW-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd;

    typedef struct {
        logic [CW-1:0] c;
        logic [AW-1:0] rd;
    } exp_t;

    exp_t sb[$];
    logic adv = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_op(if_op),
        .if_rs(if_rs), .if_rt(if_rt), .if_rd(if_rd),
        .if_fault(if_fault), .stall_ext(stall_ext), .flush(flush),
        .id_stall(id_stall),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .halt_out(halt_out), .err_out(err_out)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        if_op    = '0;
        if_rs    = '0;
        if_rt    = '0;
        if_rd    = '0;
        if_fault = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [AW-1:0] rs,
                         input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic f);
        if_valid = 1'b1;
        if_op    = op;
        if_rs    = rs;
        if_rt    = rt;
        if_rd    = rd;
        if_fault = f;
    endtask

    task automatic push(input logic [CW-1:0] c, input logic [AW-1:0] rd);
        exp_t e;
        e.c  = c;
        e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic drain();
        idle();
        repeat (5) tick();
    endtask

    // WB advanced on the last edge when not stalled and not in reset
    always @(posedge clk) adv <= rst_n && !stall_ext;

    // Monitor: each newly retired valid bundle must match the queue head
    always @(negedge clk) begin
        if (adv && rst_n && wb_ctrl[B_VALID]) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wb_unexpected: got %0h expected none",
                         wb_ctrl);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_bundle", 32'(wb_ctrl), 32'(e.c));
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            end
        end
    end

    logic [4:0]    s_op[9]  = '{OP_XORI, OP_ST, OP_BEQZ, OP_SLBI, OP_JR,
                                OP_STU, OP_LBI, OP_BTR, OP_ROLI};
    logic [CW-1:0] s_exp[9] = '{K_XORI, K_ST, K_BEQZ, K_SLBI, K_JR,
                                K_STU, K_LBI, K_BTR, K_ROLI};

    initial begin
        idle();
        stall_ext = 1'b0;
        flush     = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ex", 32'(ex_ctrl), 0);
        chk("rst_mem", 32'(mem_ctrl), 0);
        chk("rst_wb", 32'(wb_ctrl), 0);
        chk("rst_flags", {id_stall, halt_out, err_out}, 0);
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // ADDI latency: EX at t+1, WB at t+3
        drive(OP_ADDI, 0, 0, 1, 1'b0);
        push(K_ADDI, 1);
        @(negedge clk);
        chk("addi_id_stall", 32'(id_stall), 0);
        tick();
        idle();
        @(negedge clk);
        chk("addi_ex", 32'(ex_ctrl), 32'(K_ADDI));
        chk("addi_ex_rd", 32'(ex_rd), 1);
        tick();
        tick();
        @(negedge clk);
        chk("addi_wb_t3", 32'(wb_ctrl), 32'(K_ADDI));
        drain();

        // Opcode sweep back-to-back
        for (int i = 0; i < 9; i++) begin
            drive(s_op[i], 0, 0, AW'(i), 1'b0);
            push(s_exp[i], AW'(i));
            tick();
        end
        drain();

        // Load-use: LD r3 then ADD reading r3
        drive(OP_LD, 0, 0, 3, 1'b0);
        push(K_LD, 3);
        tick();
        drive(OP_ADD, 3, 0, 2, 1'b0);
        push(K_ADD, 2);
        @(negedge clk);
`ifdef CTRL_LOADUSE_EN
        chk("lu_stall", 32'(id_stall), 1);
        tick();
        @(negedge clk);
        chk("lu_bubble", 32'(ex_ctrl), 0);
        chk("lu_stall_once", 32'(id_stall), 0);
        tick();
        idle();
        @(negedge clk);
        chk("lu_add_ex", 32'(ex_ctrl), 32'(K_ADD));
`else
        chk("lu_nostall", 32'(id_stall), 0);
        tick();
        idle();
        @(negedge clk);
        chk("lu_add_ex", 32'(ex_ctrl), 32'(K_ADD));
`endif
        drain();

        // Flush and load-use together: flush wins, no stall
        drive(OP_LD, 0, 0, 4, 1'b0);
        push(K_LD, 4);
        tick();
        drive(OP_ADD, 4, 4, 6, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_lu_stall", 32'(id_stall), 0);
        tick();
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("fl_lu_ex", 32'(ex_ctrl), 0);
        drain();

        // External stall with three bundles in flight
        drive(OP_ADDI, 0, 0, 1, 1'b0);
        push(K_ADDI, 1);
        tick();
        drive(OP_LD, 0, 0, 5, 1'b0);
        push(K_LD, 5);
        tick();
        drive(OP_ADD, 1, 2, 2, 1'b0);
        push(K_ADD, 2);
        tick();
        idle();
        stall_ext = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stl_ex", 32'(ex_ctrl), 32'(K_ADD));
            chk("stl_mem", 32'(mem_ctrl), 32'(K_LD));
            chk("stl_wb", 32'(wb_ctrl), 32'(K_ADDI));
            chk("stl_rds", {ex_rd, mem_rd, wb_rd}, {3'd2, 3'd5, 3'd1});
            tick();
            if (c == 1) stall_ext = 1'b0;
        end
        @(negedge clk);
        chk("stl_resume_mem", 32'(mem_ctrl), 32'(K_ADD));
        chk("stl_resume_wb", 32'(wb_ctrl), 32'(K_LD));
        drain();

        // Flush squashes SUBI behind JAL
        drive(OP_JAL, 0, 0, 7, 1'b0);
        push(K_JAL, 7);
        tick();
        drive(OP_SUBI, 1, 1, 2, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        @(negedge clk);
        chk("fl_ex_bubble", 32'(ex_ctrl), 0);
        chk("fl_jal_mem", 32'(mem_ctrl), 32'(K_JAL));
        drain();

        // Reset mid-stream with LD in MEM
        drive(OP_LD, 0, 0, 3, 1'b0);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("mid_ld_mem", 32'(mem_ctrl), 32'(K_LD));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'(ex_ctrl | mem_ctrl | wb_ctrl), 0);
        chk("mid_rst_rd", {ex_rd, mem_rd, wb_rd}, 0);
        chk("mid_rst_flags", {id_stall, halt_out, err_out}, 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("mid_empty", 32'(ex_ctrl | mem_ctrl | wb_ctrl), 0);
        drain();

        // Faulted instruction alone: sticky err_out at t+3
        drive(OP_ADDI, 0, 0, 5, 1'b1);
        push(K_FLT, 0);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("flt_err_t2", 32'(err_out), 0);
        tick();
        @(negedge clk);
        chk("flt_err_t3", 32'(err_out), 1);
        repeat (3) tick();
        @(negedge clk);
        chk("flt_err_sticky", 32'(err_out), 1);
        chk("flt_no_halt", 32'(halt_out), 0);
        rst_n = 1'b0;
        #1;
        chk("flt_err_rst", 32'(err_out), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // HALT, then ADDI and a faulted op are squashed
        drive(OP_HALT, 0, 0, 0, 1'b0);
        push(K_HALT, 0);
        tick();
        drive(OP_ADDI, 0, 0, 1, 1'b0);
        tick();
        drive(OP_ADDI, 0, 0, 1, 1'b1);
        @(negedge clk);
        chk("hlt_ex_bubble", 32'(ex_ctrl), 0);
        chk("hlt_t2", 32'(halt_out), 0);
        tick();
        drive(OP_ADDI, 0, 0, 1, 1'b0);
        @(negedge clk);
        chk("hlt_t3", 32'(halt_out), 1);
        repeat (5) tick();
        @(negedge clk);
        chk("hlt_sticky", 32'(halt_out), 1);
        chk("hlt_no_err", 32'(err_out), 0);
        chk("hlt_squash", 32'(ex_ctrl | mem_ctrl | wb_ctrl), 0);
        idle();
        tick();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
